meas_seq_ctrl: RTL and testbench



---
 rtl/meas_seq_ctrl_if.sv | 24 ++
 rtl/meas_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_meas_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/meas_seq_ctrl_if.sv
// Word-stream bundle between the host side and the measurement sequencer:
// a load stream (s_*) into the sequencer and an unload stream (m_*) out of it.
interface meas_seq_ctrl_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    // host side
    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid
    );

    // sequencer side
    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid
    );
endinterface

// File: rtl/meas_seq_ctrl.sv
// Measurement sequencer: fills wide DUT input vectors word by word, strobes the DUT,
// waits a settle delay, captures the wide DUT outputs and streams them back out.
module meas_seq_ctrl #(
    parameter int WORD_W      = 32,
    parameter int VEC_W       = 9984,
    parameter int NUM_VEC     = 3,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                       sys_clk_p,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    meas_seq_ctrl_if.slave             bus,
    output logic [NUM_VEC*VEC_W-1:0]   dut_in,
    output logic                       dut_en,
    input  logic [NUM_VEC*VEC_W-1:0]   dut_out
);
    localparam int WPV    = VEC_W / WORD_W;
    localparam int TOTAL  = NUM_VEC * WPV;
    localparam int VW     = NUM_VEC * VEC_W;
    localparam int CNT_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int WCNT_W = $clog2(WAIT_CYCLES + 1);
    localparam int IDX_W  = (VW > 1) ? $clog2(VW) : 1;

    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(TOTAL - 1);
    localparam logic [WCNT_W-1:0] LAST_WAIT = WCNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LAUNCH,
        S_WAIT,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  word_cnt, word_cnt_nxt;
    logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [VW-1:0]     capture;
    logic              load_we;
    logic              cap_we;
    logic [IDX_W-1:0]  word_base;

    // Bit offset of the current word; shared by the load write and the unload read.
    assign word_base = IDX_W'(word_cnt) * IDX_W'(WORD_W);

    always_ff @(posedge sys_clk_p) begin
        if (reset) begin
            state    <= S_IDLE;
            word_cnt <= '0;
            wait_cnt <= '0;
            capture  <= '0;
            dut_in   <= '0;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (load_we) begin
                dut_in[word_base +: WORD_W] <= bus.s_data;
            end
            if (cap_we) begin
                capture <= dut_out;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        wait_cnt_nxt = wait_cnt;
        load_we      = 1'b0;
        cap_we       = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        dut_en       = 1'b0;
        bus.s_ready  = 1'b0;
        bus.m_valid  = 1'b0;
        bus.m_data   = '0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt    = S_LOAD;
                    word_cnt_nxt = '0;
                end
            end

            S_LOAD: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) begin
                    load_we = 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        state_nxt = S_LAUNCH;
                    end else begin
                        word_cnt_nxt = word_cnt + 1'b1;
                    end
                end
            end

            S_LAUNCH: begin
                dut_en       = 1'b1;
                wait_cnt_nxt = '0;
                state_nxt    = S_WAIT;
            end

            // Capture on the last settle cycle so the DUT gets WAIT_CYCLES-1 extra cycles.
            S_WAIT: begin
                if (wait_cnt == LAST_WAIT) begin
                    cap_we       = 1'b1;
                    word_cnt_nxt = '0;
                    state_nxt    = S_UNLOAD;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end

            S_UNLOAD: begin
                bus.m_valid = 1'b1;
                bus.m_data  = capture[word_base +: WORD_W];
                if (bus.m_ready) begin
                    if (word_cnt == LAST_WORD) begin
                        state_nxt = S_DONE;
                    end else begin
                        word_cnt_nxt = word_cnt + 1'b1;
                    end
                end
            end

            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_meas_seq_ctrl.sv
// Bench for meas_seq_ctrl: two instances (settle 1 with a 1-register DUT, settle 4
// with a 3-stage DUT) share stimulus; each is scored against the words it was fed.
module tb_meas_seq_ctrl;
    localparam int WORD_W  = 32;
    localparam int VEC_W   = 64;
    localparam int NUM_VEC = 3;
    localparam int TOTAL   = NUM_VEC * VEC_W / WORD_W;
    localparam int VW      = NUM_VEC * VEC_W;
    localparam int WAIT_A  = 1;
    localparam int WAIT_B  = 4;
    localparam int LAT_B   = 3;

    logic sys_clk_p = 1'b0;
    always #5 sys_clk_p = ~sys_clk_p;

    logic              reset   = 1'b1;
    logic              start   = 1'b0;
    logic              s_valid = 1'b0;
    logic              m_ready = 1'b0;
    logic [WORD_W-1:0] s_data  = '0;

    meas_seq_ctrl_if #(.WORD_W(WORD_W)) a_if ();
    meas_seq_ctrl_if #(.WORD_W(WORD_W)) b_if ();

    assign a_if.s_data  = s_data;
    assign a_if.s_valid = s_valid;
    assign a_if.m_ready = m_ready;
    assign b_if.s_data  = s_data;
    assign b_if.s_valid = s_valid;
    assign b_if.m_ready = m_ready;

    logic [VW-1:0] dut_in_a, dut_in_b, dut_out_b;
    logic [VW-1:0] dut_out_a = '0;
    logic          en_a, en_b, busy_a, busy_b, done_a, done_b;

    meas_seq_ctrl #(.WORD_W(WORD_W), .VEC_W(VEC_W), .NUM_VEC(NUM_VEC), .WAIT_CYCLES(WAIT_A)) u_a (
        .sys_clk_p(sys_clk_p), .reset(reset), .start(start), .busy(busy_a), .done(done_a),
        .bus(a_if), .dut_in(dut_in_a), .dut_en(en_a), .dut_out(dut_out_a)
    );

    meas_seq_ctrl #(.WORD_W(WORD_W), .VEC_W(VEC_W), .NUM_VEC(NUM_VEC), .WAIT_CYCLES(WAIT_B)) u_b (
        .sys_clk_p(sys_clk_p), .reset(reset), .start(start), .busy(busy_b), .done(done_b),
        .bus(b_if), .dut_in(dut_in_b), .dut_en(en_b), .dut_out(dut_out_b)
    );

    // DUT models: single register for A, three-stage pipeline for B.
    always @(posedge sys_clk_p) if (en_a) dut_out_a <= dut_in_a;

    logic [VW-1:0] pipe_b [LAT_B];
    initial for (int i = 0; i < LAT_B; i++) pipe_b[i] = '0;
    always @(posedge sys_clk_p) begin
        if (en_b) pipe_b[0] <= dut_in_b;
        for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign dut_out_b = pipe_b[LAT_B-1];

    logic [1:0]        busy_v, en_v, done_v, mv_v, sr_v;
    logic [WORD_W-1:0] md_v  [2];
    logic [VW-1:0]     din_v [2];
    assign busy_v   = {busy_b, busy_a};
    assign en_v     = {en_b, en_a};
    assign done_v   = {done_b, done_a};
    assign mv_v     = {b_if.m_valid, a_if.m_valid};
    assign sr_v     = {b_if.s_ready, a_if.s_ready};
    assign md_v[0]  = a_if.m_data;
    assign md_v[1]  = b_if.m_data;
    assign din_v[0] = dut_in_a;
    assign din_v[1] = dut_in_b;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        bit          rand_data;
        logic [31:0] base;
        bit          stall_s;
        bit          stall_m;
        bit          start_mid;
        int          exp_busy_a;
        int          exp_busy_b;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    task automatic do_run(input int r);
        logic [WORD_W-1:0] w [TOTAL];
        logic [WORD_W-1:0] got [2][TOTAL];
        logic [WORD_W-1:0] prev_md [2];
        logic [VW-1:0]     exp_vec;
        int gcnt[2], en_cnt[2], en_cyc[2], gap[2], busy_cyc[2], done_cnt[2];
        bit prev_done[2], hold[2];
        int ld, last_acc, cyc, exp_gap;
        bit mid_sent, finished;
        string tag;

        exp_vec = '0;
        for (int i = 0; i < TOTAL; i++) begin
            w[i] = vecs[r].rand_data ? WORD_W'($urandom) : vecs[r].base + WORD_W'(i);
            exp_vec[i*WORD_W +: WORD_W] = w[i];
        end
        for (int d = 0; d < 2; d++) begin
            gcnt[d] = 0; en_cnt[d] = 0; en_cyc[d] = -1; gap[d] = -1;
            busy_cyc[d] = 0; done_cnt[d] = 0; prev_done[d] = 0; hold[d] = 0; prev_md[d] = '0;
        end

        @(negedge sys_clk_p);
        start = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        @(negedge sys_clk_p);
        ld = 0; last_acc = -100; finished = 0; mid_sent = 0;

        for (cyc = 0; cyc < 300 && !finished; cyc++) begin
            s_valid = (ld < TOTAL) && (!vecs[r].stall_s || $urandom_range(0, 1) != 0);
            s_data  = (ld < TOTAL) ? w[ld] : WORD_W'($urandom);
            m_ready = !vecs[r].stall_m || $urandom_range(0, 2) != 0;
            start   = 1'b0;
            if (vecs[r].start_mid && !mid_sent && mv_v[0]) begin
                start    = 1'b1;
                mid_sent = 1'b1;
            end

            for (int d = 0; d < 2; d++) begin
                tag = $sformatf("run%0d dut%0d", r, d);
                check({tag, " s_ready"}, VW'(sr_v[d]), VW'(ld < TOTAL));
                if (busy_v[d]) busy_cyc[d]++;
                if (en_v[d]) begin
                    en_cnt[d]++;
                    en_cyc[d] = cyc;
                    check({tag, " dut_en cycle"}, VW'(cyc), VW'(last_acc + 1));
                    check({tag, " dut_in packing"}, din_v[d], exp_vec);
                end
                if (mv_v[d] && gap[d] < 0 && en_cyc[d] >= 0) gap[d] = cyc - en_cyc[d];
                if (hold[d]) begin
                    check({tag, " m_valid hold"}, VW'(mv_v[d]), VW'(1));
                    check({tag, " m_data hold"}, VW'(md_v[d]), VW'(prev_md[d]));
                end
                hold[d]    = mv_v[d] && !m_ready;
                prev_md[d] = md_v[d];
                if (mv_v[d] && m_ready) begin
                    if (gcnt[d] < TOTAL) got[d][gcnt[d]] = md_v[d];
                    gcnt[d]++;
                end
                if (prev_done[d]) check({tag, " busy after done"}, VW'(busy_v[d]), VW'(0));
                if (done_v[d]) begin
                    done_cnt[d]++;
                    check({tag, " busy during done"}, VW'(busy_v[d]), VW'(1));
                end
                prev_done[d] = done_v[d];
            end

            if (s_valid && sr_v[0]) begin
                ld++;
                last_acc = cyc;
            end
            finished = !busy_v[0] && !busy_v[1];
            @(negedge sys_clk_p);
        end
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;

        check($sformatf("run%0d completion within budget", r), VW'(finished), VW'(1));
        for (int d = 0; d < 2; d++) begin
            tag     = $sformatf("run%0d dut%0d", r, d);
            exp_gap = (d == 0) ? WAIT_A + 1 : WAIT_B + 1;
            check({tag, " dut_en pulses"}, VW'(en_cnt[d]), VW'(1));
            check({tag, " done pulses"}, VW'(done_cnt[d]), VW'(1));
            check({tag, " words unloaded"}, VW'(gcnt[d]), VW'(TOTAL));
            for (int i = 0; i < TOTAL && i < gcnt[d]; i++)
                check($sformatf("%s word%0d", tag, i), VW'(got[d][i]), VW'(w[i]));
            check({tag, " en to m_valid"}, VW'(gap[d]), VW'(exp_gap));
            if (d == 0 && vecs[r].exp_busy_a >= 0)
                check({tag, " busy cycles"}, VW'(busy_cyc[d]), VW'(vecs[r].exp_busy_a));
            if (d == 1 && vecs[r].exp_busy_b >= 0)
                check({tag, " busy cycles"}, VW'(busy_cyc[d]), VW'(vecs[r].exp_busy_b));
            check({tag, " idle after run"}, VW'(busy_v[d]), VW'(0));
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd1,          1'b0, 1'b0, 1'b0, 15, 18};
        vecs[1] = '{1'b0, 32'd1,          1'b1, 1'b1, 1'b0, -1, -1};
        vecs[2] = '{1'b1, 32'd0,          1'b0, 1'b0, 1'b0, 15, 18};
        vecs[3] = '{1'b1, 32'd0,          1'b1, 1'b0, 1'b1, -1, -1};
        vecs[4] = '{1'b1, 32'd0,          1'b0, 1'b1, 1'b0, -1, -1};
        vecs[5] = '{1'b0, 32'hFFFF_FFF0,  1'b0, 1'b0, 1'b1, 15, 18};
        vecs[6] = '{1'b1, 32'd0,          1'b1, 1'b1, 1'b1, -1, -1};

        reset = 1'b1;
        repeat (2) @(posedge sys_clk_p);
        @(negedge sys_clk_p);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset dut%0d busy", d),    VW'(busy_v[d]), VW'(0));
            check($sformatf("reset dut%0d done", d),    VW'(done_v[d]), VW'(0));
            check($sformatf("reset dut%0d s_ready", d), VW'(sr_v[d]),   VW'(0));
            check($sformatf("reset dut%0d m_valid", d), VW'(mv_v[d]),   VW'(0));
            check($sformatf("reset dut%0d m_data", d),  VW'(md_v[d]),   VW'(0));
            check($sformatf("reset dut%0d dut_en", d),  VW'(en_v[d]),   VW'(0));
            check($sformatf("reset dut%0d dut_in", d),  din_v[d],       VW'(0));
        end

        reset = 1'b0; start = 1'b1;
        @(negedge sys_clk_p);
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("start dut%0d busy", d),    VW'(busy_v[d]), VW'(1));
            check($sformatf("start dut%0d s_ready", d), VW'(sr_v[d]),   VW'(1));
        end
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = 32'hA0 + WORD_W'(i);
            @(negedge sys_clk_p);
        end
        for (int d = 0; d < 2; d++)
            check($sformatf("partial load dut%0d", d), VW'(din_v[d][95:0]), VW'(96'h000000A2_000000A1_000000A0));

        s_valid = 1'b0; reset = 1'b1;
        @(negedge sys_clk_p);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("abort dut%0d busy", d),    VW'(busy_v[d]), VW'(0));
            check($sformatf("abort dut%0d s_ready", d), VW'(sr_v[d]),   VW'(0));
            check($sformatf("abort dut%0d dut_in", d),  din_v[d],       VW'(0));
        end
        start = 1'b1;
        @(negedge sys_clk_p);
        reset = 1'b0; start = 1'b0;
        for (int d = 0; d < 2; d++)
            check($sformatf("start under reset dut%0d busy", d), VW'(busy_v[d]), VW'(0));
        @(negedge sys_clk_p);
        for (int d = 0; d < 2; d++)
            check($sformatf("start under reset dut%0d still idle", d), VW'(busy_v[d]), VW'(0));

        for (int r = 0; r < NVEC; r++) do_run(r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
